fir_mac_serial: RTL and testbench

Parametrised, time-multiplexed FIR filter that replaces the fixed 4-tap parallel-multiplier filter in the tile. One shared signed multiplier runs over N_TAPS taps per input sample. Coefficients load and reload at runtime over the same input stream. Valid/ready handshakes on input and output, plus rounding and optional saturation, let the block sit between a sample source and a downstream consumer that can stall.

---
 rtl/fir_mac_serial_if.sv | 26 ++
 rtl/fir_mac_serial.sv | 178 +++++++++++++++++
 tb/tb_fir_mac_serial.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_if.sv
// Handshake bundle for fir_mac_serial: sample/coefficient input, filtered output, reload control.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the slave side is the filter.
interface fir_mac_serial_if #(
    parameter int BW_IN  = 6,
    parameter int BW_OUT = 8
);
    logic              coef_load;
    logic              in_valid;
    logic              in_ready;
    logic [BW_IN-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BW_OUT-1:0] out_data;
    logic              coef_loaded;

    modport master (
        output coef_load, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, coef_loaded
    );

    modport slave (
        input  coef_load, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, coef_loaded
    );
endinterface

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed multiplier walks N_TAPS taps per sample, then round/saturate.
// Latency: out_valid after N_TAPS+1 edges following the input accept; N_TAPS+3 cycles per sample.
// Backpressure: output held until out_ready; in_ready low from accept until the output handshake.
module fir_mac_serial #(
    parameter int N_TAPS   = 4,
    parameter int BW_IN    = 6,
    parameter int BW_COEF  = 6,
    parameter int BW_OUT   = 8,
    parameter int SHIFT    = 6,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           reset,
    fir_mac_serial_if.slave bus
);
    localparam int BW_ACC  = BW_IN + BW_COEF + $clog2(N_TAPS);
    localparam int BW_PROD = BW_IN + BW_COEF;
    localparam int BW_R    = BW_ACC + 1;
    localparam int CW      = $clog2(N_TAPS);
    localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);

    // Rounding constant: half an output LSB, so the shift rounds half toward +inf.
    localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [BW_R-1:0] RND_HALF = (SHIFT > 0) ? (BW_R'(1) << HALF_SH) : '0;
    localparam logic signed [BW_R-1:0] OUT_MAX  = BW_R'((2 ** (BW_OUT - 1)) - 1);
    localparam logic signed [BW_R-1:0] OUT_MIN  = ~OUT_MAX;

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_MAC, S_RND, S_OUT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_in_rdy;
    logic                        w_in_acc;
    logic [CW-1:0]               r_cnt;
    logic signed [BW_COEF-1:0]   r_coef [N_TAPS];
    logic signed [BW_IN-1:0]     r_x    [N_TAPS];
    logic signed [BW_ACC-1:0]    r_acc;
    logic [BW_OUT-1:0]           r_out_data;
    logic                        r_coef_loaded;

    logic signed [BW_IN-1:0]     w_x_sel;
    logic signed [BW_COEF-1:0]   w_c_sel;
    logic signed [BW_PROD-1:0]   w_prod;
    logic signed [BW_ACC-1:0]    w_prod_ext;
    logic signed [BW_R-1:0]      w_sum;
    logic signed [BW_R-1:0]      w_rs;
    logic [BW_OUT-1:0]           w_res;

    // Shared multiplier: both operands sign-extended to the full product width.
    assign w_x_sel    = r_x[r_cnt];
    assign w_c_sel    = r_coef[r_cnt];
    assign w_prod     = $signed({{BW_COEF{w_x_sel[BW_IN-1]}}, w_x_sel})
                      * $signed({{BW_IN{w_c_sel[BW_COEF-1]}}, w_c_sel});
    assign w_prod_ext = {{(BW_ACC - BW_PROD){w_prod[BW_PROD-1]}}, w_prod};

    // One guard bit above the accumulator keeps the rounding add from overflowing.
    assign w_sum = $signed({r_acc[BW_ACC-1], r_acc}) + RND_HALF;
    assign w_rs  = w_sum >>> SHIFT;

    assign w_in_acc = bus.in_valid & w_in_rdy;

    assign bus.in_ready    = w_in_rdy;
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.out_data    = r_out_data;
    assign bus.coef_loaded = r_coef_loaded;

    // Clamp to the signed output range, or wrap to the low output bits.
    always_comb begin
        w_res = w_rs[BW_OUT-1:0];
        if (SATURATE != 0) begin
            if (w_rs > OUT_MAX) begin
                w_res = OUT_MAX[BW_OUT-1:0];
            end else if (w_rs < OUT_MIN) begin
                w_res = OUT_MIN[BW_OUT-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and in_ready; coef_load in IDLE masks in_ready so no sample slips in.
    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_rdy = 1'b1;
                if (bus.in_valid && r_cnt == LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_in_rdy = ~bus.coef_load;
                if (bus.coef_load) begin
                    w_state_nxt = S_LOAD;
                end else if (bus.in_valid) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_RND;
                end
            end
            S_RND: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Datapath: coefficient capture, delay line, accumulate, round/register result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_coef[k] <= '0;
                r_x[k]    <= '0;
            end
            r_cnt         <= '0;
            r_acc         <= '0;
            r_out_data    <= '0;
            r_coef_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_acc) begin
                        r_coef[r_cnt] <= bus.in_data[BW_COEF-1:0];
                        if (r_cnt == LAST) begin
                            r_cnt         <= '0;
                            r_coef_loaded <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_IDLE: begin
                    if (bus.coef_load) begin
                        for (int k = 0; k < N_TAPS; k++) begin
                            r_x[k] <= '0;
                        end
                        r_coef_loaded <= 1'b0;
                        r_cnt         <= '0;
                    end else if (w_in_acc) begin
                        for (int k = N_TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0] <= bus.in_data;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                end
                S_RND: begin
                    r_out_data <= w_res;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_serial.sv
module tb_fir_mac_serial;
    localparam int N      = 4;
    localparam int BW_IN  = 6;
    localparam int BW_OUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              coef_load;
    logic              in_valid;
    logic              out_ready;
    logic [BW_IN-1:0]  in_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference state: loaded coefficients and delay line, newest sample at index 0.
    int mc[N];
    int mx[N];

    fir_mac_serial_if #(.BW_IN(BW_IN), .BW_OUT(BW_OUT)) ifa ();
    fir_mac_serial_if #(.BW_IN(BW_IN), .BW_OUT(BW_OUT)) ifb ();
    fir_mac_serial_if #(.BW_IN(BW_IN), .BW_OUT(BW_OUT)) ifc ();

    assign ifa.coef_load = coef_load;
    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.coef_load = coef_load;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;
    assign ifc.coef_load = coef_load;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_data   = in_data;
    assign ifc.out_ready = out_ready;

    // Default scaling, plus two SHIFT=0 variants to reach saturation and wrap.
    fir_mac_serial u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
    fir_mac_serial #(.SHIFT(0), .SATURATE(1)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));
    fir_mac_serial #(.SHIFT(0), .SATURATE(0)) u_dut_c (.clk(clk), .reset(reset), .bus(ifc));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Dot product, round half up by 2^sh, then clamp or wrap to 8-bit signed.
    function automatic int model_out(input int sh, input bit sat);
        int y;
        int r;
        y = 0;
        for (int k = 0; k < N; k++) y += mc[k] * mx[k];
        r = (sh > 0) ? ((y + (1 << (sh - 1))) >>> sh) : y;
        if (sat) begin
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
        end else begin
            r = r & 255;
            if (r >= 128) r -= 256;
        end
        return r;
    endfunction

    // Load N coefficients while in LOAD, optionally with idle gaps between words.
    task automatic load_coefs(input int c[N], input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = BW_IN'(c[i]);
            #1;
            chk("ld_rdy", ifa.in_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) mc[i] = c[i];
        #1;
        chk("loaded", ifa.coef_loaded, 1);
    endtask

    // Request reload from IDLE with a competing sample that must be refused.
    task automatic reload();
        coef_load = 1'b1;
        in_valid  = 1'b1;
        in_data   = BW_IN'(31);
        #1;
        chk("cl_rdy", ifa.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        coef_load = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < N; i++) mx[i] = 0;
        #1;
        chk("cl_loaded", ifa.coef_loaded, 0);
        chk("cl_ldrdy", ifa.in_ready, 1);
    endtask

    // Push one sample, check latency and data, stall the output, then handshake.
    task automatic send(input int v, input int stall, output int acc_cyc,
                        output int oa, output int ob, output int oc);
        int t;
        int lat;
        logic [BW_OUT-1:0] held;
        t = 0;
        oa = 0; ob = 0; oc = 0;
        in_valid = 1'b1;
        in_data  = BW_IN'(v);
        #1;
        while (!ifa.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        acc_cyc = cyc;
        if (t >= 50) begin
            chk("rdy_tmo", 0, 1);
            in_valid = 1'b0;
            return;
        end
        for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!ifa.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, N + 1);
        oa = int'($signed(ifa.out_data));
        ob = int'($signed(ifb.out_data));
        oc = int'($signed(ifc.out_data));
        chk("out_a", oa, model_out(6, 1'b1));
        chk("out_b", ob, model_out(0, 1'b1));
        chk("out_c", oc, model_out(0, 1'b0));
        held = ifa.out_data;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_vld", ifa.out_valid, 1);
            chk("bp_dat", int'(ifa.out_data), int'(held));
            chk("bp_rdy", ifa.in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hs_vld", ifa.out_valid, 0);
        chk("hs_rdy", ifa.in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c[N];
        int imp[5];
        int ac, prev, oa, ob, oc;

        reset = 1'b1; coef_load = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin mc[i] = 0; mx[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdy", ifa.in_ready, 1);
        chk("rst_vld", ifa.out_valid, 0);
        chk("rst_dat", int'(ifa.out_data), 0);
        chk("rst_loaded", ifa.coef_loaded, 0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("quiet_rdy", ifa.in_ready, 1);
        chk("quiet_vld", ifa.out_valid, 0);
        chk("quiet_dat", int'(ifa.out_data), 0);
        chk("quiet_loaded", ifa.coef_loaded, 0);

        // Impulse through the default filter, output handshake immediate.
        c = '{8, 16, 24, 31};
        load_coefs(c, 1'b1);
        imp = '{4, 8, 12, 15, 0};
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 31 : 0, 0, ac, oa, ob, oc);
            chk("imp_val", oa, imp[i]);
            if (i > 0) chk("imp_space", ac - prev, N + 3);
            prev = ac;
        end

        // Output stall of 5 cycles.
        send(int'($urandom_range(0, 63)) - 32, 5, ac, oa, ob, oc);

        // Rounding and sign.
        reload();
        c = '{-32, 0, 0, 0};
        load_coefs(c, 1'b0);
        send(-32, 0, ac, oa, ob, oc);
        chk("rnd_neg", oa, 16);
        reload();
        c = '{1, 0, 0, 0};
        load_coefs(c, 1'b0);
        send(-32, 0, ac, oa, ob, oc);
        chk("rnd_zero", oa, 0);
        send(-31, 0, ac, oa, ob, oc);
        chk("rnd_half", oa, 0);

        // Saturation (SHIFT=0) and wrap.
        reload();
        c = '{31, 31, 31, 31};
        load_coefs(c, 1'b0);
        for (int i = 0; i < 4; i++) send(31, 0, ac, oa, ob, oc);
        chk("sat_hi", ob, 127);
        chk("wrap_hi", oc, 4);
        reload();
        c = '{-32, -32, -32, -32};
        load_coefs(c, 1'b0);
        for (int i = 0; i < 4; i++) send(31, 0, ac, oa, ob, oc);
        chk("sat_lo", ob, -128);

        // Reload must clear the delay line (currently full of 31s).
        reload();
        c = '{1, 1, 1, 1};
        load_coefs(c, 1'b0);
        send(0, 0, ac, oa, ob, oc);
        chk("clr_b", ob, 0);

        // Randomized rounds against the reference model.
        for (int r = 0; r < 4; r++) begin
            reload();
            for (int i = 0; i < N; i++) c[i] = int'($urandom_range(0, 63)) - 32;
            load_coefs(c, 1'b1);
            for (int s = 0; s < 10; s++) begin
                send(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 3)), ac, oa, ob, oc);
            end
        end

        // Reset in the middle of MAC.
        in_valid = 1'b1;
        in_data  = BW_IN'(17);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_vld", ifa.out_valid, 0);
        chk("mrst_rdy", ifa.in_ready, 1);
        chk("mrst_loaded", ifa.coef_loaded, 0);
        chk("mrst_dat", int'(ifa.out_data), 0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin mc[i] = 0; mx[i] = 0; end
        for (int i = 0; i < N; i++) c[i] = int'($urandom_range(0, 63)) - 32;
        load_coefs(c, 1'b0);
        for (int s = 0; s < 4; s++) begin
            send(int'($urandom_range(0, 63)) - 32, 1, ac, oa, ob, oc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
